// File: rtl/cla_serial_subtractor.sv
// rtl/cla_serial_subtractor.sv - slice-serial A - B - Bin using one 4-bit CLA slice per clock
module cla_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Zero,
    output logic             Ovf
);

    localparam int NSLICE = WIDTH / 4;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [KW-1:0]    k;

    logic [3:0]       a_s;
    logic [3:0]       b_s;
    logic [3:0]       p;
    logic [3:0]       g;
    logic [3:0]       c;
    logic             c4;
    logic [3:0]       sum;
    logic [WIDTH-1:0] res_next;
    logic             last;
    logic             ovf_next;

    // Subtraction as A + ~B + ~Bin: the slice sees the inverted subtrahend and carry = ~borrow.
    always_comb begin
        a_s  = a_q[{k, 2'b00} +: 4];
        b_s  = ~b_q[{k, 2'b00} +: 4];
        p    = a_s ^ b_s;
        g    = a_s & b_s;
        c[0] = carry;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum  = p ^ c;
        res_next = res;
        res_next[{k, 2'b00} +: 4] = sum;
        last     = (k == KW'(NSLICE - 1));
        ovf_next = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_next[WIDTH-1] != a_q[WIDTH-1]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            res   <= '0;
            carry <= 1'b0;
            k     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            Diff  <= '0;
            Bout  <= 1'b0;
            Zero  <= 1'b0;
            Ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        carry <= ~Bin;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res   <= res_next;
                    carry <= c4;
                    k     <= k + 1'b1;
                    // Results publish atomically only on the final slice; outputs stay frozen until then.
                    if (last) begin
                        Diff  <= res_next;
                        Bout  <= ~c4;
                        Zero  <= (res_next == '0);
                        Ovf   <= ovf_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        k     <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_serial_subtractor.sv
// tb/tb_cla_serial_subtractor.sv - directed-vector bench for cla_serial_subtractor
module tb_cla_serial_subtractor;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        Bin;
    logic        busy;
    logic        done;
    logic [15:0] Diff;
    logic        Bout;
    logic        Zero;
    logic        Ovf;

    int n_checks = 0;
    int n_pass   = 0;

    cla_serial_subtractor #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .Diff  (Diff),
        .Bout  (Bout),
        .Zero  (Zero),
        .Ovf   (Ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Called at a negedge; leaves start high across exactly one rising edge.
    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic bin);
        A = a; B = b; Bin = bin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic bin,
                      input logic [15:0] ed, input logic eb, input logic ez, input logic eo);
        int n;
        launch(a, b, bin);
        check({tag, " busy"}, {31'd0, busy}, 32'd1);
        wait_done(n);
        check({tag, " latency"}, n, 32'd4);
        check({tag, " Diff"}, {16'd0, Diff}, {16'd0, ed});
        check({tag, " flags"}, {29'd0, Bout, Zero, Ovf}, {29'd0, eb, ez, eo});
        @(negedge clk);
        check({tag, " done pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int n;
        int saw_done;
        reset = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset outs", {12'd0, busy, done, Diff, Bout, Zero, Ovf}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        op("basic",    16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        op("under",    16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        op("ripple",   16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0);
        op("ovf_neg",  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1);
        op("ovf_pos",  16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1);
        op("zero_bin", 16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
        op("bin_wrap", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);

        // Start while busy is ignored; inputs change mid-flight; start in done cycle is accepted.
        launch(16'h1234, 16'h0234, 1'b0);
        check("hold Diff", {16'd0, Diff}, 32'hFFFF);
        launch(16'hFFFF, 16'h0000, 1'b0);
        A = 16'hAAAA; B = 16'h1111;
        check("hold busy", {31'd0, busy}, 32'd1);
        wait_done(n);
        check("ignore lat", n, 32'd3);
        check("ignore Diff", {16'd0, Diff}, 32'h1000);
        launch(16'h0003, 16'h0001, 1'b0);
        check("b2b busy", {31'd0, busy}, 32'd1);
        wait_done(n);
        check("b2b lat", n, 32'd4);
        check("b2b Diff", {16'd0, Diff}, 32'h0002);
        @(negedge clk);

        // Reset after two RUN cycles abandons the operation.
        launch(16'h1234, 16'h0001, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst outs", {12'd0, busy, done, Diff, Bout, Zero, Ovf}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        check("midrst quiet", saw_done, 32'd0);
        op("after_rst", 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
